// File: rtl/jk_bank_arbiter.sv
// Round-robin arbitrated bank of JK storage bits: one requester command per clock
// is granted and applied to the addressed bit.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 6,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      j,
    input  logic [NREQ-1:0]      k,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic [2:0]           last_id,
    output logic [NBITS-1:0]     q
);

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             err_q, err_d;
    logic [2:0]       last_q, last_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [NBITS-1:0] bank_q, bank_d;

    logic [NREQ-1:0]  elig;
    logic             found;
    logic [2:0]       win;
    logic [AW-1:0]    waddr;
    logic             wj, wk;

    function automatic logic jk_next(input logic cur, input logic jj, input logic kk);
        case ({jj, kk})
            2'b01:   jk_next = 1'b0;
            2'b10:   jk_next = 1'b1;
            2'b11:   jk_next = ~cur;
            default: jk_next = cur;
        endcase
    endfunction

    // Last cycle's winner sits out one cycle so it can drop req without a double issue.
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        waddr = '0;
        wj    = 1'b0;
        wk    = 1'b0;
        if (en) begin
            for (int o = 0; o < NREQ; o++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && elig[i] && (i == ((int'(ptr_q) + o) % NREQ))) begin
                        found = 1'b1;
                        win   = 3'(i);
                        waddr = addr[i*AW +: AW];
                        wj    = j[i];
                        wk    = k[i];
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_d  = '0;
        err_d  = 1'b0;
        last_d = last_q;
        ptr_d  = ptr_q;
        bank_d = bank_q;
        if (found) begin
            gnt_d  = NREQ'(1) << win;
            last_d = win;
            ptr_d  = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
            if (int'(waddr) < NBITS) begin
                for (int b = 0; b < NBITS; b++) begin
                    if (int'(waddr) == b) begin
                        bank_d[b] = jk_next(bank_q[b], wj, wk);
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q  <= '0;
            err_q  <= 1'b0;
            last_q <= '0;
            ptr_q  <= '0;
            bank_q <= '0;
        end else begin
            gnt_q  <= gnt_d;
            err_q  <= err_d;
            last_q <= last_d;
            ptr_q  <= ptr_d;
            bank_q <= bank_d;
        end
    end

    assign gnt     = gnt_q;
    assign err     = err_q;
    assign last_id = last_q;
    assign q       = bank_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed and randomized checks of jk_bank_arbiter against a rule-level reference model.
module tb_jk_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int NBITS = 6;
    localparam int AW    = 3;

    logic                clk = 1'b0;
    logic                rst, en;
    logic [NREQ-1:0]     req, j, k;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ-1:0]     gnt;
    logic                err;
    logic [2:0]          last_id;
    logic [NBITS-1:0]    q;

    jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .j(j), .k(k), .addr(addr),
        .gnt(gnt), .err(err), .last_id(last_id), .q(q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers and a bit vector, updated from the rules.
    int               m_ptr, m_last, m_prev;
    logic [NBITS-1:0] m_q;
    logic [NREQ-1:0]  e_gnt;
    logic             e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_last = 0; m_prev = -1; m_q = '0; e_gnt = '0; e_err = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        int a;
        w = -1;
        if (en === 1'b1) begin
            for (int o = 0; o < NREQ; o++) begin
                int idx;
                idx = (m_ptr + o) % NREQ;
                if (w < 0 && req[idx] && m_prev != idx) w = idx;
            end
        end
        e_gnt = '0;
        e_err = 1'b0;
        if (w >= 0) begin
            e_gnt[w] = 1'b1;
            m_last   = w;
            m_ptr    = (w + 1) % NREQ;
            a        = int'(addr[w*AW +: AW]);
            if (a < NBITS) begin
                if (j[w] && k[w])       m_q[a] = ~m_q[a];
                else if (j[w])          m_q[a] = 1'b1;
                else if (k[w])          m_q[a] = 1'b0;
            end else begin
                e_err = 1'b1;
            end
            m_prev = w;
        end else begin
            m_prev = -1;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".last"}, 32'(last_id), 32'(m_last));
        chk({tag, ".onehot"}, 32'($onehot0(gnt)), 32'(1));
        @(negedge clk);
    endtask

    task automatic cmd(input int r, input logic jj, input logic kk, input int a, input string tag);
        req = '0; j = '0; k = '0;
        req[r] = 1'b1; j[r] = jj; k[r] = kk;
        addr[r*AW +: AW] = AW'(a);
        step(tag);
        chk({tag, ".gnt1"}, 32'(gnt), 32'(NREQ'(1) << r));
        req = '0;
        step({tag, ".idle"});
    endtask

    initial begin
        logic [NREQ-1:0]  seen;
        logic [NBITS-1:0] qsave;
        int               ngr;

        rst = 1'b1; en = 1'b1; req = '1; j = '0; k = '0; addr = '0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst.q", 32'(q), 32'(0));
        chk("rst.gnt", 32'(gnt), 32'(0));
        chk("rst.err", 32'(err), 32'(0));
        chk("rst.last", 32'(last_id), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("rel");
        chk("rel.first", 32'(gnt), 32'h1);
        req = '0;
        step("rel.idle");

        // Basic JK sequence on bit 2.
        cmd(0, 1'b1, 1'b0, 2, "jk.set");   chk("jk.set.v", 32'(q), 32'b000100);
        cmd(0, 1'b1, 1'b1, 2, "jk.tog");   chk("jk.tog.v", 32'(q), 32'b000000);
        cmd(0, 1'b1, 1'b1, 2, "jk.tog2");  chk("jk.tog2.v", 32'(q), 32'b000100);
        cmd(0, 1'b0, 1'b0, 2, "jk.hold");  chk("jk.hold.v", 32'(q), 32'b000100);
        cmd(0, 1'b0, 1'b1, 2, "jk.clr");   chk("jk.clr.v", 32'(q), 32'b000000);

        // Fairness with all requesters held.
        req = '1; j = '0; k = '0; addr = '0;
        seen = '0;
        for (int c = 0; c < 4; c++) begin
            step("fair");
            chk("fair.rep", 32'((seen & gnt) != 0), 32'(0));
            seen |= gnt;
        end
        chk("fair.all", 32'(seen), 32'hF);
        for (int c = 0; c < 4; c++) step("fair2");
        req = '0;
        step("fair.idle");

        // Collision: requesters 1 and 2 toggle bit 5.
        req = 4'b0110; j = 4'b0110; k = 4'b0110;
        addr[1*AW +: AW] = 3'd5; addr[2*AW +: AW] = 3'd5;
        ngr = 0;
        for (int c = 0; c < 4 && req != 0; c++) begin
            step("coll");
            if (gnt != 0) begin
                ngr++;
                chk("coll.q5", 32'(q[5]), (ngr == 1) ? 32'(1) : 32'(0));
            end
            req &= ~gnt;
        end
        chk("coll.ngr", 32'(ngr), 32'(2));
        chk("coll.done", 32'(req), 32'(0));

        // Out-of-range address.
        qsave = q;
        req = 4'b1000; j = 4'b1000; k = '0; addr[3*AW +: AW] = 3'd7;
        step("oor");
        chk("oor.gnt", 32'(gnt), 32'h8);
        chk("oor.err", 32'(err), 32'(1));
        chk("oor.q", 32'(q), 32'(qsave));
        req = '0;
        step("oor.idle");
        chk("oor.err0", 32'(err), 32'(0));

        // Enable low holds everything; resumes from held pointer.
        en = 1'b0; req = 4'b0011; j = 4'b0011; k = '0;
        addr[0*AW +: AW] = 3'd0; addr[1*AW +: AW] = 3'd1;
        qsave = q;
        for (int c = 0; c < 5; c++) begin
            step("en0");
            chk("en0.gnt", 32'(gnt), 32'(0));
            chk("en0.q", 32'(q), 32'(qsave));
        end
        en = 1'b1;
        step("en1");
        chk("en1.first", 32'(gnt), 32'h1);
        step("en1b");
        req = '0;
        step("en1.idle");

        // Randomized traffic.
        for (int c = 0; c < 200; c++) begin
            en   = ($urandom_range(0, 9) != 0);
            req  = NREQ'($urandom);
            j    = NREQ'($urandom);
            k    = NREQ'($urandom);
            addr = (NREQ*AW)'($urandom);
            step("rand");
        end

        // Asynchronous reset mid-burst.
        en = 1'b1;
        req = '0;
        step("pre.idle");
        cmd(0, 1'b1, 1'b0, 0, "pre.set");
        req = '1; j = '0; k = '0;
        step("burst");
        step("burst2");
        #2 rst = 1'b0;
        #1;
        chk("mrst.q", 32'(q), 32'(0));
        chk("mrst.gnt", 32'(gnt), 32'(0));
        chk("mrst.err", 32'(err), 32'(0));
        chk("mrst.last", 32'(last_id), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("post");
        chk("post.first", 32'(gnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
